// File: rtl/time_keeper_pkg.sv
// Shared definitions for the time_keeper clock: BCD digit width, digit
// limits and the two-digit BCD increment helpers used by the time counters.
package time_keeper_pkg;

   localparam int DIGIT_W = 4;

   localparam logic [DIGIT_W-1:0] LIM_UNITS    = 4'd9;  // any units digit
   localparam logic [DIGIT_W-1:0] LIM_TENS_MS  = 4'd5;  // minutes/seconds tens
   localparam logic [DIGIT_W-1:0] LIM_TENS_H   = 4'd2;  // hours tens
   localparam logic [DIGIT_W-1:0] LIM_UNITS_H2 = 4'd3;  // hours units when tens is 2
   localparam int                 LIM_HOURS    = 23;
   localparam int                 LIM_MINSEC   = 59;

   typedef struct packed {
      logic [DIGIT_W-1:0] tens;
      logic [DIGIT_W-1:0] ones;
   } bcd2_t;

   // True when a minutes/seconds pair reads 59.
   function automatic logic bcd60_is_max(input bcd2_t v);
      return (v.tens == LIM_TENS_MS) && (v.ones == LIM_UNITS);
   endfunction

   // 00..59 increment, wrapping 59 -> 00.
   function automatic bcd2_t bcd60_inc(input bcd2_t v);
      bcd2_t r;
      r = v;
      if (v.ones == LIM_UNITS) begin
         r.ones = '0;
         r.tens = (v.tens == LIM_TENS_MS) ? '0 : v.tens + 4'd1;
      end else begin
         r.ones = v.ones + 4'd1;
      end
      return r;
   endfunction

   // 00..23 increment, wrapping 23 -> 00.
   function automatic bcd2_t bcd24_inc(input bcd2_t v);
      bcd2_t r;
      r = v;
      if ((v.tens == LIM_TENS_H) && (v.ones == LIM_UNITS_H2)) begin
         r = '0;
      end else if (v.ones == LIM_UNITS) begin
         r.ones = '0;
         r.tens = v.tens + 4'd1;
      end else begin
         r.ones = v.ones + 4'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/time_keeper_if.sv
// Control and display bundle of the time_keeper clock. The master side
// drives run and the two buttons; the slave side (the clock) drives the
// BCD digits, the seconds pulse and the colon enable.
interface time_keeper_if;
   import time_keeper_pkg::*;

   logic               run;
   logic               inc_min;
   logic               inc_hr;
   logic [DIGIT_W-1:0] h10;
   logic [DIGIT_W-1:0] h1;
   logic [DIGIT_W-1:0] m10;
   logic [DIGIT_W-1:0] m1;
   logic [DIGIT_W-1:0] s10;
   logic [DIGIT_W-1:0] s1;
   logic               sec_tick;
   logic               colon;

   modport master (
      output run, inc_min, inc_hr,
      input  h10, h1, m10, m1, s10, s1, sec_tick, colon
   );

   modport slave (
      input  run, inc_min, inc_hr,
      output h10, h1, m10, m1, s10, s1, sec_tick, colon
   );

endinterface

// File: rtl/time_keeper_prescaler.sv
// Seconds prescaler: counts clock cycles within one second, flags the last
// cycle of each second and produces the registered colon blink enable.
module tick_prescaler #(
   parameter int TICKS_PER_SEC = 10000000
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic clr,
   output logic tick,
   output logic colon
);

   localparam int CNT_W = $clog2(TICKS_PER_SEC);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);
   localparam logic [CNT_W-1:0] HALF = CNT_W'(TICKS_PER_SEC / 2);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             colon_q, colon_d;

   assign tick  = run && (cnt_q == LAST);
   assign colon = colon_q;

   // Next count: clear on minute set, wrap at end of second, hold when stopped.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (run) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
      end
      colon_d = (cnt_d < HALF) || !run;
   end

   // Count and colon registers; colon comes out of reset lit.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         colon_q <= 1'b1;
      end else begin
         cnt_q   <= cnt_d;
         colon_q <= colon_d;
      end
   end

endmodule

// File: rtl/time_keeper.sv
// 24-hour HH:MM:SS clock with BCD outputs, run/freeze control and two
// set buttons (minutes, hours) brought in through synchronizers.
module time_keeper
   import time_keeper_pkg::*;
#(
   parameter int TICKS_PER_SEC = 10000000
) (
   input  logic          ADC_CLK_10,
   input  logic          reset,
   time_keeper_if.slave  tk
);

   // Index 0 = inc_min, index 1 = inc_hr.
   logic [1:0] btn;
   logic [1:0] sync1_q, sync1_d;
   logic [1:0] sync2_q, sync2_d;
   logic [1:0] dly_q, dly_d;
   logic [1:0] ev;
   logic       ev_min, ev_hr;

   bcd2_t hr_q, hr_d;
   bcd2_t min_q, min_d;
   bcd2_t sec_q, sec_d;

   logic tick;
   logic colon;
   logic sec_wrap, min_wrap;

   assign btn    = {tk.inc_hr, tk.inc_min};
   assign ev     = sync2_q & ~dly_q;
   assign ev_min = ev[0];
   assign ev_hr  = ev[1];

   // Synchronizer chain and edge register feed forward one stage per cycle.
   always_comb begin
      sync1_d = btn;
      sync2_d = sync1_q;
      dly_d   = sync2_q;
   end

   // Button registers reset high so a button held through reset is not an event.
   always_ff @(posedge ADC_CLK_10) begin
      if (reset) begin
         sync1_q <= '1;
         sync2_q <= '1;
         dly_q   <= '1;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         dly_q   <= dly_d;
      end
   end

   tick_prescaler #(
      .TICKS_PER_SEC (TICKS_PER_SEC)
   ) u_prescaler (
      .clk   (ADC_CLK_10),
      .rst   (reset),
      .run   (tk.run),
      .clr   (ev_min),
      .tick  (tick),
      .colon (colon)
   );

   // Time update: minute set beats the tick; hour set swallows a tick carry into hours.
   always_comb begin
      sec_d    = sec_q;
      min_d    = min_q;
      hr_d     = hr_q;
      sec_wrap = bcd60_is_max(sec_q);
      min_wrap = bcd60_is_max(min_q);
      if (ev_min) begin
         sec_d = '0;
         min_d = bcd60_inc(min_q);
      end else if (tick) begin
         sec_d = bcd60_inc(sec_q);
         if (sec_wrap) begin
            min_d = bcd60_inc(min_q);
         end
      end
      if (ev_hr || (tick && !ev_min && sec_wrap && min_wrap)) begin
         hr_d = bcd24_inc(hr_q);
      end
   end

   // Time-of-day registers, cleared to 00:00:00 by reset.
   always_ff @(posedge ADC_CLK_10) begin
      if (reset) begin
         hr_q  <= '0;
         min_q <= '0;
         sec_q <= '0;
      end else begin
         hr_q  <= hr_d;
         min_q <= min_d;
         sec_q <= sec_d;
      end
   end

   assign tk.h10      = hr_q.tens;
   assign tk.h1       = hr_q.ones;
   assign tk.m10      = min_q.tens;
   assign tk.m1       = min_q.ones;
   assign tk.s10      = sec_q.tens;
   assign tk.s1       = sec_q.ones;
   assign tk.sec_tick = tick;
   assign tk.colon    = colon;

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper with a one-second prescale of four cycles. A model
// of the clock in plain integer hours/minutes/seconds is advanced at every
// rising edge; a compare process checks all outputs against it on every
// falling edge, and directed scenarios pin literal times.
module tb_time_keeper;

   localparam int T = 4;

   logic clk = 1'b0;
   logic rst_i = 1'b1;
   logic run_i = 1'b0;
   logic min_i = 1'b0;
   logic hr_i  = 1'b0;

   time_keeper_if tk ();

   assign tk.run     = run_i;
   assign tk.inc_min = min_i;
   assign tk.inc_hr  = hr_i;

   time_keeper #(.TICKS_PER_SEC(T)) dut (
      .ADC_CLK_10 (clk),
      .reset      (rst_i),
      .tk         (tk)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int tick_cnt = 0;
   bit chk_en = 1'b0;

   // model state
   int m_hh = 0, m_mm = 0, m_ss = 0, m_presc = 0;
   bit m_colon = 1'b1;
   bit [2:0] hist_min = 3'b111;   // [0] = sample at last edge
   bit [2:0] hist_hr  = 3'b111;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance the model by one rising edge using the inputs present at that edge.
   task automatic model_edge();
      bit em, eh, tck;
      int pn;
      if (rst_i) begin
         m_hh = 0; m_mm = 0; m_ss = 0; m_presc = 0; m_colon = 1'b1;
         hist_min = 3'b111; hist_hr = 3'b111;
         return;
      end
      em  = hist_min[1] && !hist_min[2];
      eh  = hist_hr[1]  && !hist_hr[2];
      hist_min = {hist_min[1:0], min_i};
      hist_hr  = {hist_hr[1:0], hr_i};
      tck = run_i && (m_presc == T - 1);
      if (em)         pn = 0;
      else if (run_i) pn = (m_presc + 1) % T;
      else            pn = m_presc;
      if (em) begin
         m_mm = (m_mm + 1) % 60;
         m_ss = 0;
      end else if (tck) begin
         m_ss++;
         if (m_ss == 60) begin
            m_ss = 0;
            m_mm++;
            if (m_mm == 60) begin
               m_mm = 0;
               if (!eh) m_hh = (m_hh + 1) % 24;
            end
         end
      end
      if (eh) m_hh = (m_hh + 1) % 24;
      m_presc = pn;
      m_colon = (pn < T / 2) || !run_i;
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         model_edge();
         #1;
      end
   endtask

   task automatic pulse_min(input int k);
      repeat (k) begin
         min_i = 1'b1; cyc(1);
         min_i = 1'b0; cyc(1);
      end
      cyc(3);
   endtask

   task automatic pulse_hr(input int k);
      repeat (k) begin
         hr_i = 1'b1; cyc(1);
         hr_i = 1'b0; cyc(1);
      end
      cyc(3);
   endtask

   function automatic logic [23:0] digits(input int h, input int m, input int s);
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   task automatic check_time(input string name, input int h, input int m, input int s);
      check({name, "_dut"}, {8'd0, tk.h10, tk.h1, tk.m10, tk.m1, tk.s10, tk.s1}, {8'd0, digits(h, m, s)});
      check({name, "_model"}, {8'd0, digits(m_hh, m_mm, m_ss)}, {8'd0, digits(h, m, s)});
   endtask

   logic [25:0] act_v, exp_v;
   logic        legal;

   // Every cycle: all outputs against the model, plus digit legality.
   always @(negedge clk) begin
      if (chk_en) begin
         act_v = {tk.h10, tk.h1, tk.m10, tk.m1, tk.s10, tk.s1, tk.colon, tk.sec_tick};
         exp_v = {digits(m_hh, m_mm, m_ss), m_colon, run_i && (m_presc == T - 1)};
         check("outputs", {6'd0, act_v}, {6'd0, exp_v});
         legal = (tk.h10 <= 4'd2) && (tk.h1 <= 4'd9) && ((tk.h10 != 4'd2) || (tk.h1 <= 4'd3)) &&
                 (tk.m10 <= 4'd5) && (tk.m1 <= 4'd9) && (tk.s10 <= 4'd5) && (tk.s1 <= 4'd9);
         check("bcd_legal", {31'd0, legal}, 32'd1);
         if (tk.sec_tick) tick_cnt++;
      end
   end

   int t0;

   initial begin
      // reset state and colon cadence
      cyc(2);
      chk_en = 1'b1;
      rst_i = 1'b0;
      check_time("reset", 0, 0, 0);
      check("reset_colon", {31'd0, tk.colon}, 32'd1);
      check("reset_tick", {31'd0, tk.sec_tick}, 32'd0);
      run_i = 1'b1;
      t0 = tick_cnt;
      check("colon_0", {31'd0, tk.colon}, 32'd1);
      cyc(1); check("colon_1", {31'd0, tk.colon}, 32'd1);
      cyc(1); check("colon_2", {31'd0, tk.colon}, 32'd0);
      cyc(1); check("colon_3", {31'd0, tk.colon}, 32'd0);
      cyc(237);
      check("tick_count_240", tick_cnt - t0, 32'd60);
      check_time("one_minute", 0, 1, 0);

      // set 23:59, run to 23:59:59 and roll over midnight
      run_i = 1'b0;
      pulse_hr(23);
      pulse_min(58);
      check_time("set_2359", 23, 59, 0);
      run_i = 1'b1;
      cyc(59 * T);
      check_time("pre_midnight", 23, 59, 59);
      cyc(T);
      check_time("midnight", 0, 0, 0);

      // 12:59:30 then minute set, and minute set colliding with a tick
      run_i = 1'b0;
      pulse_hr(12);
      pulse_min(59);
      run_i = 1'b1;
      cyc(30 * T);
      run_i = 1'b0;
      check_time("at_125930", 12, 59, 30);
      min_i = 1'b1; cyc(1);
      min_i = 1'b0; cyc(1);
      check_time("min_latency", 12, 59, 30);
      cyc(1);
      check_time("min_applied", 12, 0, 0);
      run_i = 1'b1;
      cyc(1);
      min_i = 1'b1; cyc(1);
      min_i = 1'b0; cyc(1);
      check("tick_pending", {31'd0, tk.sec_tick}, 32'd1);
      cyc(1);
      check_time("min_vs_tick", 12, 1, 0);

      // frozen time, buttons still work
      run_i = 1'b0;
      t0 = tick_cnt;
      cyc(100);
      check("frozen_ticks", tick_cnt - t0, 32'd0);
      check_time("frozen", 12, 1, 0);
      pulse_hr(1);
      check_time("hr_while_stopped", 13, 1, 0);

      // randomized traffic
      repeat (3000) begin
         run_i = ($urandom_range(0, 3) != 0);
         min_i = ($urandom_range(0, 15) == 0);
         hr_i  = ($urandom_range(0, 15) == 0);
         rst_i = ($urandom_range(0, 499) == 0);
         cyc(1);
      end
      rst_i = 1'b0; min_i = 1'b0; hr_i = 1'b0; run_i = 1'b0;
      cyc(4);

      // hour button held through reset release
      rst_i = 1'b1; hr_i = 1'b1;
      cyc(2);
      rst_i = 1'b0;
      cyc(5);
      hr_i = 1'b0;
      cyc(4);
      check_time("hr_held_reset", 0, 0, 0);

      // reset mid-second at 05:17:42
      pulse_hr(5);
      pulse_min(17);
      run_i = 1'b1;
      cyc(42 * T + 2);
      check_time("at_051742", 5, 17, 42);
      rst_i = 1'b1;
      cyc(1);
      rst_i = 1'b0;
      check_time("reset_mid", 0, 0, 0);
      check("reset_mid_colon", {31'd0, tk.colon}, 32'd1);
      cyc(8);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
